// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 LCD sequencer: state encoding,
// init command ROM, command codes and ASCII case-swap helpers.
package lcd_ctrl_pkg;

   typedef enum logic [2:0] {
      S_PWRUP_WAIT = 3'd0,
      S_INIT_LOAD  = 3'd1,
      S_SETUP      = 3'd2,
      S_E_HIGH     = 3'd3,
      S_HOLD       = 3'd4,
      S_EXEC_WAIT  = 3'd5,
      S_IDLE       = 3'd6
   } lcd_state_e;

   localparam int INIT_LEN = 6;

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   localparam logic [7:0] ASCII_UC_LO = 8'h41;
   localparam logic [7:0] ASCII_UC_HI = 8'h5A;
   localparam logic [7:0] ASCII_LC_LO = 8'h61;
   localparam logic [7:0] ASCII_LC_HI = 8'h7A;
   localparam logic [7:0] CASE_DELTA  = 8'h20;

   // 8-bit bus, 2 lines, display on, entry increment, then clear.
   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      case (idx)
         3'd0, 3'd1, 3'd2: init_rom = 8'h38;
         3'd3:             init_rom = 8'h0C;
         3'd4:             init_rom = 8'h06;
         3'd5:             init_rom = CMD_CLEAR;
         default:          init_rom = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] swap_case(input logic [7:0] b);
      if (b >= ASCII_LC_LO && b <= ASCII_LC_HI)      swap_case = b - CASE_DELTA;
      else if (b >= ASCII_UC_LO && b <= ASCII_UC_HI) swap_case = b + CASE_DELTA;
      else                                           swap_case = b;
   endfunction

   // Clear and Home need the long execution wait; everything else is short.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
      is_long_cmd = !rs && (b == CMD_CLEAR || b == CMD_HOME || b == CMD_HOME_ALT);
   endfunction

   function automatic int imax(input int a, input int b);
      imax = (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command/data FIFO with first-word fall-through. A push while full is
// dropped and reported as a one-cycle ovf_pulse; full is judged before any
// same-cycle pop.
module lcd_cmd_fifo
   import lcd_ctrl_pkg::*;
#(
   parameter int AW = 3,
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_req,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          ovf_pulse
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [0:DEPTH-1];
   logic [DW-1:0] mem_d [0:DEPTH-1];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          push, do_pop;

   assign full      = (level_q == (AW+1)'(DEPTH));
   assign empty     = (level_q == '0);
   assign level     = level_q;
   assign head      = mem_q[rd_ptr_q];
   assign push      = push_req && !full;
   assign ovf_pulse = push_req && full;
   assign do_pop    = pop && !empty;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, do_pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Register FIFO state; reset empties it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// HD44780 16x2 LCD sequencer: power-up wait, init ROM playback, then FIFO
// draining with counter-paced setup / E pulse / hold / execution timing.
module lcd_seq_ctrl
   import lcd_ctrl_pkg::*;
#(
   parameter int FIFO_AW     = 3,
   parameter int T_SETUP_CYC = 4,
   parameter int T_E_CYC     = 13,
   parameter int T_HOLD_CYC  = 2,
   parameter int T_EXEC_CYC  = 2000,
   parameter int T_LONG_CYC  = 82000,
   parameter int T_PWRUP_CYC = 750000
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             WR_STB,
   input  logic [8:0]       WR_DATA,
   input  logic             CASE_SWAP_EN,
   input  logic             CLR_OVF,
   output logic             LCD_RS,
   output logic             LCD_RW,
   output logic             LCD_E,
   output logic [7:0]       LCD_DATA,
   output logic             BUSY,
   output logic             INIT_DONE,
   output logic             FIFO_FULL,
   output logic             OVERFLOW,
   output logic [FIFO_AW:0] LEVEL
);

   localparam int T_MAX = imax(imax(T_PWRUP_CYC, T_LONG_CYC),
                               imax(T_EXEC_CYC, imax(T_E_CYC, imax(T_SETUP_CYC, T_HOLD_CYC))));
   localparam int CNT_W = $clog2(T_MAX) + 1;

   lcd_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, exec_last;
   logic [2:0]       idx_q, idx_d;
   logic             e_q, e_d, rs_q, rs_d, done_q, done_d, ovf_q, ovf_d;
   logic [7:0]       data_q, data_d;
   logic [8:0]       head;
   logic             fifo_empty, pop, ovf_pulse;

   lcd_cmd_fifo #(.AW(FIFO_AW), .DW(9)) u_fifo (
      .clk       (CLK),
      .rst       (RESET),
      .push_req  (WR_STB),
      .push_data (WR_DATA),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .full      (FIFO_FULL),
      .level     (LEVEL),
      .ovf_pulse (ovf_pulse)
   );

   // Execution wait depends on the word currently on the bus.
   assign exec_last = is_long_cmd(rs_q, data_q) ? CNT_W'(T_LONG_CYC - 1)
                                                : CNT_W'(T_EXEC_CYC - 1);

   // Sequencer next-state: each timed phase ends when cnt reaches its length-1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      e_d     = e_q;
      rs_d    = rs_q;
      data_d  = data_q;
      done_d  = done_q;
      pop     = 1'b0;
      case (state_q)
         S_PWRUP_WAIT: if (cnt_q == CNT_W'(T_PWRUP_CYC - 1)) begin
            state_d = S_INIT_LOAD;
            cnt_d   = '0;
            idx_d   = '0;
         end
         S_INIT_LOAD: begin
            rs_d    = 1'b0;
            data_d  = init_rom(idx_q);
            state_d = S_SETUP;
            cnt_d   = '0;
         end
         S_IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               rs_d    = head[8];
               data_d  = (CASE_SWAP_EN && head[8]) ? swap_case(head[7:0]) : head[7:0];
               state_d = S_SETUP;
            end
         end
         S_SETUP: if (cnt_q == CNT_W'(T_SETUP_CYC - 1)) begin
            state_d = S_E_HIGH;
            e_d     = 1'b1;
            cnt_d   = '0;
         end
         S_E_HIGH: if (cnt_q == CNT_W'(T_E_CYC - 1)) begin
            state_d = S_HOLD;
            e_d     = 1'b0;
            cnt_d   = '0;
         end
         S_HOLD: if (cnt_q == CNT_W'(T_HOLD_CYC - 1)) begin
            state_d = S_EXEC_WAIT;
            cnt_d   = '0;
         end
         S_EXEC_WAIT: if (cnt_q == exec_last) begin
            cnt_d = '0;
            if (done_q) begin
               state_d = S_IDLE;
            end else if (idx_q == 3'(INIT_LEN - 1)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = S_INIT_LOAD;
            end
         end
         default: begin
            state_d = S_PWRUP_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Sticky overflow: a dropped write beats a simultaneous clear.
   always_comb begin
      ovf_d = ovf_q;
      if (CLR_OVF)   ovf_d = 1'b0;
      if (ovf_pulse) ovf_d = 1'b1;
   end

   // Register sequencer state and panel outputs; reset restarts init.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_PWRUP_WAIT;
         cnt_q   <= '0;
         idx_q   <= '0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         e_q     <= e_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign LCD_E     = e_q;
   assign LCD_RS    = rs_q;
   assign LCD_RW    = 1'b0;
   assign LCD_DATA  = data_q;
   assign INIT_DONE = done_q;
   assign OVERFLOW  = ovf_q;
   assign BUSY      = (state_q != S_IDLE) || !fifo_empty;

endmodule
